// File: rtl/mul_share_arbiter_if.sv
// Bundle of requester, multiplier and result-stream signals around mul_share_arbiter.
// A beat transfers on a rising clk edge where vld and rdy are both 1; a source holds its beat stable until then, and vld never waits on rdy. m_* has no rdy: every m_vld beat is consumed.
interface mul_share_arbiter_if #(
    parameter int QW = 5,
    parameter int UW = 1
);
    logic          r0_vld, r0_rdy, r0_last;
    logic [QW-1:0] r0_p;
    logic [UW-1:0] r0_u;
    logic          r1_vld, r1_rdy, r1_last;
    logic [QW-1:0] r1_p;
    logic [UW-1:0] r1_u;
    logic          m_vld, m_last;
    logic [QW-1:0] m_p;
    logic [UW-1:0] m_u;
    logic          z_vld, z_last, z_rdy;
    logic [QW-1:0] z;
    logic          o0_vld, o0_last, o0_rdy;
    logic [QW-1:0] o0_z;
    logic          o1_vld, o1_last, o1_rdy;
    logic [QW-1:0] o1_z;
    logic          busy, err_len;

    modport slave (
        input  r0_vld, r0_last, r0_p, r0_u, r1_vld, r1_last, r1_p, r1_u,
        input  z_vld, z_last, z, o0_rdy, o1_rdy,
        output r0_rdy, r1_rdy, m_vld, m_last, m_p, m_u, z_rdy,
        output o0_vld, o0_last, o0_z, o1_vld, o1_last, o1_z, busy, err_len
    );

    modport master (
        output r0_vld, r0_last, r0_p, r0_u, r1_vld, r1_last, r1_p, r1_u,
        output z_vld, z_last, z, o0_rdy, o1_rdy,
        input  r0_rdy, r1_rdy, m_vld, m_last, m_p, m_u, z_rdy,
        input  o0_vld, o0_last, o0_z, o1_vld, o1_last, o1_z, busy, err_len
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin frame arbiter sharing one polynomial multiplier between two requesters.
// Optional frame-length enforcement with err_len pulse: define MUL_ARB_LEN_CHECK_EN.
module mul_share_arbiter #(
    parameter int N   = 4,
    parameter int QW  = 5,
    parameter int UW  = 1,
    parameter int IDD = 2
) (
    input  logic                clk,
    input  logic                s_rst_n,
    mul_share_arbiter_if.slave  bus,
    output logic [1:0]          state_dbg
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = (IDD > 1) ? $clog2(IDD) : 1;
    localparam int OW = $clog2(IDD + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           rr_pref, rr_nx;
    logic [IDD-1:0] id_mem;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [OW-1:0]  occ;

    logic           fifo_full, fifo_empty, head, pop, push, push_id;
    logic           gsel, at_end;
    logic           rx_vld, rx_last;
    logic [QW-1:0]  rx_p;
    logic [UW-1:0]  rx_u;
    logic           r0_rdy_c, r1_rdy_c, m_vld_c, m_last_c;
    logic [QW-1:0]  m_p_c;
    logic [UW-1:0]  m_u_c;
`ifdef MUL_ARB_LEN_CHECK_EN
    logic           len_err, err_q;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(IDD - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full  = (occ == OW'(IDD));
    assign fifo_empty = (occ == '0);
    assign head       = id_mem[rd_ptr];

    // Return path: the oldest granted ID owns the z stream.
    assign bus.z_rdy   = !fifo_empty && (head ? bus.o1_rdy : bus.o0_rdy);
    assign bus.o0_vld  = !fifo_empty && !head && bus.z_vld;
    assign bus.o1_vld  = !fifo_empty &&  head && bus.z_vld;
    assign bus.o0_last = !fifo_empty && !head && bus.z_last;
    assign bus.o1_last = !fifo_empty &&  head && bus.z_last;
    assign bus.o0_z    = (!fifo_empty && !head) ? bus.z : '0;
    assign bus.o1_z    = (!fifo_empty &&  head) ? bus.z : '0;
    assign pop         = bus.z_vld && bus.z_rdy && bus.z_last;

    assign gsel    = (state == G1);
    assign rx_vld  = gsel ? bus.r1_vld  : bus.r0_vld;
    assign rx_last = gsel ? bus.r1_last : bus.r0_last;
    assign rx_p    = gsel ? bus.r1_p    : bus.r0_p;
    assign rx_u    = gsel ? bus.r1_u    : bus.r0_u;
    assign at_end  = (cnt == CW'(N - 1));

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rr_nx    = rr_pref;
        push     = 1'b0;
        push_id  = 1'b0;
        r0_rdy_c = 1'b0;
        r1_rdy_c = 1'b0;
        m_vld_c  = 1'b0;
        m_last_c = 1'b0;
        m_p_c    = '0;
        m_u_c    = '0;
`ifdef MUL_ARB_LEN_CHECK_EN
        len_err  = 1'b0;
`endif
        case (state)
            IDLE: begin
                // A full FIFO still admits a grant when its head pops this cycle.
                if ((!fifo_full || pop) && (bus.r0_vld || bus.r1_vld)) begin
                    push     = 1'b1;
                    push_id  = (bus.r0_vld && bus.r1_vld) ? rr_pref : bus.r1_vld;
                    state_nx = push_id ? G1 : G0;
                end
            end
            G0, G1: begin
                r0_rdy_c = !gsel;
                r1_rdy_c = gsel;
                m_vld_c  = rx_vld;
                m_p_c    = rx_p;
                m_u_c    = rx_u;
`ifdef MUL_ARB_LEN_CHECK_EN
                m_last_c = at_end || rx_last;
                len_err  = rx_vld && (rx_last != at_end);
`else
                m_last_c = rx_last;
`endif
                if (rx_vld) begin
                    if (m_last_c) begin
                        cnt_nx   = '0;
                        rr_nx    = !gsel;
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = at_end ? '0 : cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rr_pref <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            rr_pref <= rr_nx;
        end
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            id_mem <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                id_mem[wr_ptr] <= push_id;
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      occ <= occ + 1'b1;
            else if (pop && !push) occ <= occ - 1'b1;
        end
    end

`ifdef MUL_ARB_LEN_CHECK_EN
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) err_q <= 1'b0;
        else          err_q <= len_err;
    end
    assign bus.err_len = err_q;
`else
    assign bus.err_len = 1'b0;
`endif

    assign bus.r0_rdy = r0_rdy_c;
    assign bus.r1_rdy = r1_rdy_c;
    assign bus.m_vld  = m_vld_c;
    assign bus.m_last = m_last_c;
    assign bus.m_p    = m_p_c;
    assign bus.m_u    = m_u_c;
    assign bus.busy   = (state != IDLE) || !fifo_empty;
    assign state_dbg  = state;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: directed frames, a stand-in multiplier, and per-requester result scoreboards.
module tb_mul_share_arbiter;
  localparam int N = 4, QW = 5, UW = 1, IDD = 2, TMO = 200;
`ifdef MUL_ARB_LEN_CHECK_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic s_rst_n;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  mul_share_arbiter_if #(.QW(QW), .UW(UW)) bus ();
  mul_share_arbiter #(.N(N), .QW(QW), .UW(UW), .IDD(IDD)) dut (
    .clk(clk), .s_rst_n(s_rst_n), .bus(bus.slave), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  logic in_frame = 1'b0;
  logic [QW:0] exp0_q[$];
  logic [QW:0] exp1_q[$];
  logic        exp_g_q[$];
  logic [QW:0] mbuf[$];
  logic [QW:0] zq[$];

  int ptab [14][4] = '{
    '{30, 8, 31, 4}, '{1, 2, 3, 4}, '{5, 6, 7, 9}, '{10, 11, 12, 13},
    '{14, 15, 16, 17}, '{18, 19, 20, 21}, '{22, 23, 24, 25}, '{26, 27, 28, 29},
    '{0, 31, 1, 30}, '{2, 29, 3, 28}, '{7, 7, 7, 7}, '{9, 10, 11, 12},
    '{3, 6, 12, 24}, '{17, 18, 19, 20}};
  logic [3:0] utab [14] = '{4'b1111, 4'b1010, 4'b0110, 4'b1100, 4'b0011, 4'b1001, 4'b0101,
                            4'b1111, 4'b0000, 4'b1110, 4'b1111, 4'b0111, 4'b1011, 4'b0001};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_extra(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got beat %0h expected none at %0t", name, act, $time);
  endtask

  // Stand-in for multiplier_top: coefficient-wise map, result frame follows the input frame.
  function automatic logic [QW-1:0] mul_model(input logic [QW-1:0] p, input logic u);
    return u ? ~p : p;
  endfunction

  always @(negedge clk) begin
    if (!s_rst_n) begin
      mbuf.delete();
      zq.delete();
    end else begin
      if (bus.z_vld && bus.z_rdy && zq.size() > 0) void'(zq.pop_front());
      if (bus.m_vld) begin
        mbuf.push_back({bus.m_last, mul_model(bus.m_p, bus.m_u[0])});
        if (bus.m_last) begin
          foreach (mbuf[i]) zq.push_back(mbuf[i]);
          mbuf.delete();
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (zq.size() > 0) begin
      bus.z_vld = 1'b1;
      {bus.z_last, bus.z} = zq[0];
    end else begin
      bus.z_vld = 1'b0;
      bus.z_last = 1'b0;
      bus.z = '0;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin : mon
    logic [QW:0] e;
    logic g;
    if (!s_rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (bus.o0_vld && bus.o0_rdy) begin
        if (exp0_q.size() == 0) fail_extra("o0_unexpected", {bus.o0_last, bus.o0_z});
        else begin
          e = exp0_q.pop_front();
          check("o0_beat", {bus.o0_last, bus.o0_z}, e);
        end
      end
      if (bus.o1_vld && bus.o1_rdy) begin
        if (exp1_q.size() == 0) fail_extra("o1_unexpected", {bus.o1_last, bus.o1_z});
        else begin
          e = exp1_q.pop_front();
          check("o1_beat", {bus.o1_last, bus.o1_z}, e);
        end
      end
      if (bus.o0_vld || bus.o1_vld) check("o_exclusive", bus.o0_vld & bus.o1_vld, 0);
      if (bus.m_vld) begin
        g = bus.r1_rdy;
        if (!in_frame) begin
          if (exp_g_q.size() == 0) fail_extra("grant_unexpected", g);
          else check("grant", g, exp_g_q.pop_front());
          in_frame = 1'b1;
        end
        if (g) check("m_beat", {bus.m_last, bus.m_u, bus.m_p}, {bus.r1_last, bus.r1_u, bus.r1_p});
        else   check("m_beat", {bus.m_last, bus.m_u, bus.m_p}, {bus.r0_last, bus.r0_u, bus.r0_p});
        if (bus.m_last) in_frame = 1'b0;
      end
      if (bus.err_len) err_cnt++;
    end
  end

  // driver tasks
  task automatic set_req(input bit id, input logic v, input logic [QW-1:0] p, input logic u, input logic l);
    if (id) begin
      bus.r1_vld = v; bus.r1_p = p; bus.r1_u = u; bus.r1_last = l;
    end else begin
      bus.r0_vld = v; bus.r0_p = p; bus.r0_u = u; bus.r0_last = l;
    end
  endtask

  task automatic drive_beat(input bit id, input logic [QW-1:0] p, input logic u, input logic l,
                            output int waits);
    set_req(id, 1'b1, p, u, l);
    waits = 0;
    forever begin
      @(negedge clk);
      if (id ? bus.r1_rdy : bus.r0_rdy) break;
      waits++;
      if (waits >= TMO) begin
        fail_extra("accept_timeout", waits);
        break;
      end
    end
    @(posedge clk);
    #1;
    set_req(id, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input bit id, input int f, input int nb);
    int w;
    logic [QW-1:0] p;
    logic u;
    for (int b = 0; b < nb; b++) begin
      p = QW'(ptab[f][b]);
      u = utab[f][b];
      if (id) exp1_q.push_back({b == nb - 1, mul_model(p, u)});
      else    exp0_q.push_back({b == nb - 1, mul_model(p, u)});
    end
    for (int b = 0; b < nb; b++)
      drive_beat(id, QW'(ptab[f][b]), utab[f][b], b == nb - 1, w);
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((exp0_q.size() > 0 || exp1_q.size() > 0 || exp_g_q.size() > 0 || bus.busy) && c < TMO) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c >= TMO) begin
      errors++;
      $display("FAIL drain_timeout: got %0d cycles expected < %0d", c, TMO);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    s_rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    int w;
    int e0;
    set_req(1'b0, 1'b0, '0, 1'b0, 1'b0);
    set_req(1'b1, 1'b0, '0, 1'b0, 1'b0);
    bus.z_vld = 1'b0; bus.z_last = 1'b0; bus.z = '0;
    bus.o0_rdy = 1'b1; bus.o1_rdy = 1'b1;
    s_rst_n = 1'b0;
    #3;
    check("rst_r0_rdy", bus.r0_rdy, 0);
    check("rst_r1_rdy", bus.r1_rdy, 0);
    check("rst_m_vld", bus.m_vld, 0);
    check("rst_z_rdy", bus.z_rdy, 0);
    check("rst_o_vld", {bus.o0_vld, bus.o1_vld}, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err_len", bus.err_len, 0);
    check("rst_state", state_dbg, 0);
    repeat (2) @(posedge clk);
    #1;
    s_rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single r0 frame, hand-computed results, one-cycle bubble before the first beat
    exp_g_q.push_back(1'b0);
    exp0_q.push_back({1'b0, 5'd1});
    exp0_q.push_back({1'b0, 5'd23});
    exp0_q.push_back({1'b0, 5'd0});
    exp0_q.push_back({1'b1, 5'd27});
    for (int b = 0; b < 4; b++) begin
      drive_beat(1'b0, QW'(ptab[0][b]), 1'b1, b == 3, w);
      check("t1_accept_wait", w, (b == 0) ? 1 : 0);
    end
    wait_drain();
    check("t1_idle_state", state_dbg, 0);

    // 2: both requesters back-to-back, grants alternate
    do_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_g_q.push_back(1'b0);
      exp_g_q.push_back(1'b1);
    end
    fork
      begin
        send_frame(1'b0, 1, 4); send_frame(1'b0, 3, 4); send_frame(1'b0, 5, 4);
      end
      begin
        send_frame(1'b1, 2, 4); send_frame(1'b1, 4, 4); send_frame(1'b1, 6, 4);
      end
    join
    wait_drain();

    // 3: result backpressure fills the ID FIFO and stalls requesters
    bus.o0_rdy = 1'b0;
    repeat (3) exp_g_q.push_back(1'b0);
    send_frame(1'b0, 7, 4);
    send_frame(1'b0, 8, 4);
    fork
      send_frame(1'b0, 9, 4);
      begin
        repeat (6) begin
          @(negedge clk);
          check("t3_r0_rdy_stall", bus.r0_rdy, 0);
          check("t3_z_rdy_stall", bus.z_rdy, 0);
        end
        check("t3_busy", bus.busy, 1);
        @(posedge clk);
        #1;
        bus.o0_rdy = 1'b1;
      end
    join
    wait_drain();

    // 4: asynchronous reset after beat 2, then a clean r1 frame
    exp_g_q.push_back(1'b0);
    drive_beat(1'b0, QW'(ptab[10][0]), utab[10][0], 1'b0, w);
    drive_beat(1'b0, QW'(ptab[10][1]), utab[10][1], 1'b0, w);
    set_req(1'b0, 1'b1, QW'(ptab[10][2]), utab[10][2], 1'b0);
    #2;
    s_rst_n = 1'b0;
    #1;
    check("t4_r0_rdy", bus.r0_rdy, 0);
    check("t4_m_vld", bus.m_vld, 0);
    check("t4_z_rdy", bus.z_rdy, 0);
    check("t4_o_vld", {bus.o0_vld, bus.o1_vld}, 0);
    check("t4_busy", bus.busy, 0);
    check("t4_err_len", bus.err_len, 0);
    check("t4_state", state_dbg, 0);
    set_req(1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    s_rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_g_q.push_back(1'b1);
    send_frame(1'b1, 11, 4);
    wait_drain();

    // 5/6: short frame (last on beat 3), then a normal frame
    e0 = err_cnt;
    exp_g_q.push_back(1'b0);
    exp_g_q.push_back(1'b0);
    send_frame(1'b0, 12, 3);
    send_frame(1'b0, 13, 4);
    wait_drain();
    check("t5_err_len_pulses", err_cnt - e0, EXP_ERR);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
